// File: rtl/shr_operand_fifo_pkg.sv
// Shared widths and helpers for the shifter operand-pair FIFO.
package shr_operand_fifo_pkg;

  localparam int JOIN_SIZE = 2;

  // Bits needed to index n states; never less than 1 so DEPTH=1 still has a pointer.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int pair_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/join_type.sv
// N-way valid/ready join: output valid only when every input is valid, and
// each input is accepted only together with all the others.
module join_type #(
  parameter int SIZE = 2
) (
  input  logic [SIZE-1:0] ins_valid,
  input  logic            outs_ready,
  output logic [SIZE-1:0] ins_ready,
  output logic            outs_valid
);

  always_comb begin
    outs_valid = &ins_valid;
    ins_ready  = '0;
    for (int i = 0; i < SIZE; i++) begin
      ins_ready[i] = outs_ready;
      for (int j = 0; j < SIZE; j++) begin
        if (j != i) ins_ready[i] = ins_ready[i] & ins_valid[j];
      end
    end
  end

endmodule

// File: rtl/shr_operand_fifo.sv
// Joins lhs/rhs tokens into pairs and buffers them in a DEPTH-entry circular
// FIFO in front of the logical-right-shift unit.
module shr_operand_fifo
  import shr_operand_fifo_pkg::*;
#(
  parameter int DATA_TYPE = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] lhs,
  input  logic                 lhs_valid,
  output logic                 lhs_ready,
  input  logic [DATA_TYPE-1:0] rhs,
  input  logic                 rhs_valid,
  output logic                 rhs_ready,
  output logic [DATA_TYPE-1:0] outs_lhs,
  output logic [DATA_TYPE-1:0] outs_rhs,
  output logic                 outs_valid,
  input  logic                 outs_ready
);

  localparam int PTR_W  = clog2_min1(DEPTH);
  localparam int CNT_W  = clog2_min1(DEPTH + 1);
  localparam int PAIR_W = pair_w(DATA_TYPE);

  logic [PAIR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_join_ready;
  logic                 w_join_valid;
  logic [JOIN_SIZE-1:0] w_ins_ready;
  logic                 w_push;
  logic                 w_pop;
  logic [PAIR_W-1:0]    w_head;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Gating with rst keeps both readies low while reset is held, even though
  // the cleared count alone would report "not full".
  assign w_join_ready = !w_full & rst;

  join_type #(
    .SIZE(JOIN_SIZE)
  ) u_join (
    .ins_valid  ({rhs_valid, lhs_valid}),
    .outs_ready (w_join_ready),
    .ins_ready  (w_ins_ready),
    .outs_valid (w_join_valid)
  );

  assign lhs_ready = w_ins_ready[0];
  assign rhs_ready = w_ins_ready[1];

  assign w_push = w_join_valid & w_join_ready;
  assign w_pop  = !w_empty & outs_ready;

  assign w_head     = r_mem[r_rd_ptr];
  assign outs_valid = !w_empty;
  assign outs_lhs   = w_head[PAIR_W-1:DATA_TYPE];
  assign outs_rhs   = w_head[DATA_TYPE-1:0];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {lhs, rhs};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_shr_operand_fifo.sv
// Scoreboard bench for shr_operand_fifo: driver queues expected pairs, a
// negedge monitor checks every accepted head pair in order.
module tb_shr_operand_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] lhs;
  logic          lhs_valid;
  logic          lhs_ready;
  logic [DW-1:0] rhs;
  logic          rhs_valid;
  logic          rhs_ready;
  logic [DW-1:0] outs_lhs;
  logic [DW-1:0] outs_rhs;
  logic          outs_valid;
  logic          outs_ready;

  int tests;
  int fails;
  logic [2*DW-1:0] exp_q [$];
  bit prod_done;

  shr_operand_fifo #(
    .DATA_TYPE (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lhs        (lhs),
    .lhs_valid  (lhs_valid),
    .lhs_ready  (lhs_ready),
    .rhs        (rhs),
    .rhs_valid  (rhs_valid),
    .rhs_ready  (rhs_ready),
    .outs_lhs   (outs_lhs),
    .outs_rhs   (outs_rhs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake visible at the negedge is consumed at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && outs_valid && outs_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", {outs_lhs, outs_rhs}, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          chk("pop_data", {outs_lhs, outs_rhs}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic present(input logic [DW-1:0] l, input logic [DW-1:0] r);
    lhs = l;
    rhs = r;
    lhs_valid = 1'b1;
    rhs_valid = 1'b1;
    exp_q.push_back({l, r});
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lhs_ready && rhs_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty_seen;
    empty_seen = 0;
    @(posedge clk);
    #1;
    outs_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!outs_valid) begin
        empty_seen = 1;
        break;
      end
    end
    chk("drain_empty", {63'd0, empty_seen}, 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    prod_done = 0;
    rst = 1'b0;
    lhs = '0;
    rhs = '0;
    lhs_valid = 1'b1;
    rhs_valid = 1'b1;
    outs_ready = 1'b0;

    // Reset state: readies gated even with both valids high
    @(negedge clk);
    chk("rst_outs_valid", {63'd0, outs_valid}, 64'd0);
    chk("rst_outs_lhs", 64'(outs_lhs), 64'd0);
    chk("rst_outs_rhs", 64'(outs_rhs), 64'd0);
    chk("rst_lhs_ready", {63'd0, lhs_ready}, 64'd0);
    chk("rst_rhs_ready", {63'd0, rhs_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_lhs_ready", {63'd0, lhs_ready}, 64'd0);

    // Join skew: lhs waits three cycles for rhs
    @(posedge clk);
    #1;
    lhs = 32'h8000_0000;
    lhs_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("skew_lhs_ready", {63'd0, lhs_ready}, 64'd0);
      chk("skew_rhs_ready", {63'd0, rhs_ready}, 64'd1);
      chk("skew_no_output", {63'd0, outs_valid}, 64'd0);
      @(posedge clk);
      #1;
    end
    present(32'h8000_0000, 32'd4);
    wait_accept();
    @(negedge clk);
    chk("skew_outs_valid", {63'd0, outs_valid}, 64'd1);
    chk("skew_outs_lhs", 64'(outs_lhs), 64'h8000_0000);
    chk("skew_outs_rhs", 64'(outs_rhs), 64'd4);

    // Fill to full with the consumer stalled
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      present(32'(k), 32'(k + 8));
      wait_accept();
    end
    present(32'd5, 32'd13);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("full_lhs_ready", {63'd0, lhs_ready}, 64'd0);
      chk("full_rhs_ready", {63'd0, rhs_ready}, 64'd0);
      chk("stall_outs_valid", {63'd0, outs_valid}, 64'd1);
      chk("stall_outs_lhs", 64'(outs_lhs), 64'h8000_0000);
      chk("stall_outs_rhs", 64'(outs_rhs), 64'd4);
    end

    // Full with simultaneous pop: pop wins this cycle, push lands the next
    @(posedge clk);
    #1;
    outs_ready = 1'b1;
    @(negedge clk);
    chk("fullpop_lhs_ready", {63'd0, lhs_ready}, 64'd0);
    @(posedge clk);
    #1;
    outs_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_lhs_ready", {63'd0, lhs_ready}, 64'd1);
    chk("after_pop_rhs_ready", {63'd0, rhs_ready}, 64'd1);
    chk("after_pop_head_lhs", 64'(outs_lhs), 64'd1);
    @(posedge clk);
    #1;
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
    @(negedge clk);
    chk("refull_lhs_ready", {63'd0, lhs_ready}, 64'd0);
    drain();

    // Wrap-around ordering under random back-pressure
    prod_done = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          @(posedge clk);
          #1;
          present(32'(i), 32'(i % 32));
          wait_accept();
        end
        prod_done = 1;
      end
      begin
        while (!prod_done) begin
          @(posedge clk);
          #1;
          outs_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Reset mid-operation discards buffered pairs
    @(posedge clk);
    #1;
    outs_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      present(32'h11 + 32'(k), 32'(k));
      wait_accept();
    end
    @(negedge clk);
    chk("prefill_outs_valid", {63'd0, outs_valid}, 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_outs_valid", {63'd0, outs_valid}, 64'd0);
    chk("async_rst_outs_lhs", 64'(outs_lhs), 64'd0);
    chk("async_rst_outs_rhs", 64'(outs_rhs), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    present(32'hAA, 32'd1);
    wait_accept();
    @(negedge clk);
    chk("rerun_head_lhs", 64'(outs_lhs), 64'hAA);
    chk("rerun_head_rhs", 64'(outs_rhs), 64'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
